button_pio_irq: RTL and testbench

Parametrised Avalon-MM input PIO for push-buttons and switches. It adds per-bit synchronisation, counter-based debounce, edge capture with write-1-to-clear, and a maskable level interrupt. It sits on the system interconnect as a slave with fixed 1-cycle read latency and replaces the plain read-only button port wherever software needs interrupts or bounce-free reads.

---
 rtl/button_pio_irq.sv | 132 +++++++++++++
 tb/tb_button_pio_irq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/button_pio_irq.sv
// button_pio_irq: memory-mapped input port for push-buttons and switches.
// It synchronises each input, debounces it with a per-bit counter, latches
// selected edges into write-1-to-clear capture bits and raises a masked,
// level-sensitive interrupt. Reads are registered (1-cycle latency).
//
// Ports:
//   clk, reset_n      system clock, asynchronous active-low reset
//   address[1:0]      register select (0 data, 1 irqmask, 2 edgecapture, 3 raw sync)
//   chipselect        slave select, qualifies writes only
//   write_n           active-low write strobe
//   writedata[W-1:0]  write data
//   in_port[W-1:0]    asynchronous button inputs
//   readdata[W-1:0]   registered read data (updated every clock from address)
//   irq               active-high level interrupt
module button_pio_irq #(
  parameter int               WIDTH           = 5,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter int               EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE     = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [WIDTH-1:0] writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] readdata,
  output logic             irq
);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] r_stable;
  logic [WIDTH-1:0] r_irqmask;
  logic [WIDTH-1:0] r_edgecap;

  logic [WIDTH-1:0] w_sync;   // synchroniser output
  logic [WIDTH-1:0] w_src;    // value loaded into r_stable when a bit updates
  logic [WIDTH-1:0] w_upd;    // per-bit: r_stable changes at the next edge
  logic [WIDTH-1:0] w_edge;   // per-bit: qualifying edge, sets capture
  logic [WIDTH-1:0] w_clr;    // per-bit write-1-to-clear request
  logic             w_wr;

  // Synchroniser chain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= RESET_VALUE;
    end else begin
      r_sync[0] <= in_port;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      // Without debounce the stable register loads from the same stage as
      // the last sync flop, so stable always equals sync and an edge is
      // captured on the same clock that sync changes.
      assign w_src = r_sync[SYNC_STAGES-2];
      assign w_upd = w_src ^ r_stable;
    end else begin : g_debounce
      localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

      logic [CW-1:0]    r_cnt [WIDTH];
      logic [WIDTH-1:0] w_diff;

      assign w_src  = w_sync;
      assign w_diff = w_sync ^ r_stable;

      // The first differing cycle counts as 1; the load happens on the
      // DEBOUNCE_CYCLES-th consecutive differing cycle.
      always_comb begin
        w_upd = '0;
        for (int i = 0; i < WIDTH; i++) begin
          w_upd[i] = w_diff[i] && (r_cnt[i] == LAST);
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
        end else begin
          for (int i = 0; i < WIDTH; i++) begin
            // A bounce back to the stable level restarts the count.
            if (!w_diff[i] || (r_cnt[i] == LAST)) r_cnt[i] <= '0;
            else                                  r_cnt[i] <= r_cnt[i] + CW'(1);
          end
        end
      end
    end
  endgenerate

  always_comb begin
    case (EDGE_TYPE)
      0:       w_edge = w_upd & w_src;
      1:       w_edge = w_upd & ~w_src;
      default: w_edge = w_upd;
    endcase
  end

  assign w_wr  = chipselect & ~write_n;
  assign w_clr = (w_wr && (address == 2'd2)) ? writedata : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stable  <= RESET_VALUE;
      r_irqmask <= '0;
      r_edgecap <= '0;
      readdata  <= '0;
    end else begin
      r_stable <= (r_stable & ~w_upd) | (w_src & w_upd);
      if (w_wr && (address == 2'd1)) r_irqmask <= writedata;
      // Set is OR-ed after the clear so a same-cycle edge wins.
      r_edgecap <= (r_edgecap & ~w_clr) | w_edge;
      // Registered every cycle regardless of chipselect; a same-cycle
      // write is therefore not visible until the following read.
      case (address)
        2'd0:    readdata <= r_stable;
        2'd1:    readdata <= r_irqmask;
        2'd2:    readdata <= r_edgecap;
        default: readdata <= w_sync;
      endcase
    end
  end

  assign irq = |(r_edgecap & r_irqmask);

endmodule

// File: tb/tb_button_pio_irq.sv
// Directed bench for button_pio_irq: one instance with a 4-cycle debounce
// and falling-edge capture, one with debounce bypassed and any-edge capture.
// Both share the bus signals; each has its own button inputs and outputs.
module tb_button_pio_irq;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] address;
  logic       chipselect;
  logic       write_n;
  logic [4:0] writedata;
  logic [4:0] in_port;
  logic [4:0] in_port2;
  logic [4:0] readdata;
  logic [4:0] readdata2;
  logic       irq;
  logic       irq2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  button_pio_irq #(
    .WIDTH(5), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1), .RESET_VALUE(5'h1F)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  button_pio_irq #(
    .WIDTH(5), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2), .RESET_VALUE(5'h1F)
  ) dut2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port2),
    .readdata(readdata2), .irq(irq2)
  );

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Single-cycle bus write; returns just after the write edge.
  task automatic wr(input logic [1:0] a, input logic [4:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = d;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  initial begin
    // ---------------- reset ----------------
    reset_n    = 1'b0;
    in_port    = 5'h1F;
    in_port2   = 5'h1F;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    #23;
    check("rst_readdata", readdata, 5'h00);
    check("rst_irq", {4'b0, irq}, 5'h00);
    check("rst_readdata2", readdata2, 5'h00);
    check("rst_irq2", {4'b0, irq2}, 5'h00);
    reset_n = 1'b1;
    tick(2);
    check("rst_data", readdata, 5'h1F);
    check("rst_data2", readdata2, 5'h1F);
    address = 2'd2;
    tick(1);
    check("rst_edgecap", readdata, 5'h00);
    check("rst_no_irq", {4'b0, irq}, 5'h00);

    // ---------------- clean press on bit 0 ----------------
    wr(2'd1, 5'h1F);
    address = 2'd2;
    in_port = 5'h1E;               // E0 is the next edge
    tick(5);                       // after E0+4
    check("press_irq_e4", {4'b0, irq}, 5'h00);
    check("press_cap_e4", readdata, 5'h00);
    tick(1);                       // after E0+5
    check("press_irq_e5", {4'b0, irq}, 5'h01);
    tick(1);
    check("press_cap_e6", readdata, 5'h01);
    address = 2'd0;
    tick(1);
    check("press_data", readdata, 5'h1E);
    wr(2'd2, 5'h1F);
    check("press_clr_irq", {4'b0, irq}, 5'h00);
    wr(2'd1, 5'h04);

    // ---------------- bounce on bit 2 ----------------
    address = 2'd0;
    tick(1);
    for (int k = 0; k < 10; k++) begin
      in_port[2] = ~in_port[2];
      repeat (3) begin
        tick(1);
        check("bounce_data", readdata, 5'h1E);
        check("bounce_irq", {4'b0, irq}, 5'h00);
      end
    end
    in_port[2] = 1'b0;             // final transition, held
    tick(5);
    check("bounce_irq_e4", {4'b0, irq}, 5'h00);
    tick(1);
    check("bounce_irq_e5", {4'b0, irq}, 5'h01);
    check("bounce_data_e5", readdata, 5'h1E);
    tick(1);
    check("bounce_data_e6", readdata, 5'h1A);
    address = 2'd2;
    tick(1);
    check("bounce_cap", readdata, 5'h04);
    wr(2'd2, 5'h04);
    check("bounce_clr_irq", {4'b0, irq}, 5'h00);

    // ---------------- irq and mask ----------------
    wr(2'd1, 5'h00);
    in_port = 5'h18;               // press bit 1
    tick(8);
    check("mask0_irq", {4'b0, irq}, 5'h00);
    address = 2'd2;
    tick(1);
    check("mask0_cap", readdata, 5'h02);
    check("mask0_irq2", {4'b0, irq}, 5'h00);
    wr(2'd1, 5'h02);
    check("mask_prewrite_read", readdata, 5'h00);
    check("mask_irq_on", {4'b0, irq}, 5'h01);
    tick(1);
    check("mask_read", readdata, 5'h02);
    wr(2'd2, 5'h02);
    check("w1c_irq_off", {4'b0, irq}, 5'h00);
    address = 2'd2;
    tick(1);
    check("w1c_cap", readdata, 5'h00);

    // ---------------- set/clear collision on bit 3 ----------------
    wr(2'd1, 5'h08);
    in_port = 5'h10;               // press bit 3, E0 next edge
    tick(5);                       // after E0+4
    check("coll_irq_e4", {4'b0, irq}, 5'h00);
    wr(2'd2, 5'h08);               // W1C lands on E0+5, same edge as capture
    check("coll_irq", {4'b0, irq}, 5'h01);
    check("coll_prewrite_read", readdata, 5'h00);
    tick(1);
    check("coll_cap", readdata, 5'h08);
    wr(2'd2, 5'h08);
    check("coll_clr_irq", {4'b0, irq}, 5'h00);

    // ---------------- bypassed debounce, any edge ----------------
    in_port2 = 5'h0F;
    tick(4);
    wr(2'd2, 5'h1F);
    wr(2'd1, 5'h10);
    check("any_idle_irq2", {4'b0, irq2}, 5'h00);
    address = 2'd3;
    tick(1);
    in_port2 = 5'h1F;              // release bit 4
    tick(1);
    check("rel_irq2_e0", {4'b0, irq2}, 5'h00);
    check("rel_sync_e0", readdata2, 5'h0F);
    tick(1);
    check("rel_irq2_e1", {4'b0, irq2}, 5'h01);
    check("rel_sync_e1", readdata2, 5'h0F);
    tick(1);
    check("rel_sync_e2", readdata2, 5'h1F);
    wr(2'd2, 5'h10);
    check("rel_clr_irq2", {4'b0, irq2}, 5'h00);
    address = 2'd3;
    tick(1);
    in_port2 = 5'h0F;              // press bit 4
    tick(1);
    check("prs_irq2_e0", {4'b0, irq2}, 5'h00);
    check("prs_sync_e0", readdata2, 5'h1F);
    tick(1);
    check("prs_irq2_e1", {4'b0, irq2}, 5'h01);
    tick(1);
    check("prs_sync_e2", readdata2, 5'h0F);
    address = 2'd2;
    tick(1);
    check("prs_cap2", readdata2, 5'h10);
    address = 2'd0;
    tick(1);
    check("prs_data2", readdata2, 5'h0F);
    check("dut1_quiet_irq", {4'b0, irq}, 5'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
